// File: rtl/morse_sequencer.sv
// -----------------------------------------------------------------------------
// morse_sequencer
//
// Character-level scheduler for the Morse LED path. Characters arrive through a
// valid/ready handshake and are buffered in a small FIFO. Each character is
// looked up in a combinational Morse ROM and played out on the LED one unit per
// i_tick strobe, with inter-letter and inter-word gaps inserted automatically.
//
// Ports
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_tick   : one-cycle strobe marking each Morse unit boundary
//   i_char   : ASCII character (lowercase is folded to uppercase)
//   i_valid  : i_char valid
//   o_ready  : character can be accepted (FIFO not full)
//   o_led    : registered Morse output, 1 = on
//   o_busy   : sequencer active or FIFO holding characters
//   o_err    : one-cycle pulse after an unsupported character is consumed
//
// State     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | nothing playing; next tick starts the FIFO head, if any
// ST_SYMBOL | shifting out the on/off units of a letter or digit
// ST_GAP    | counting off units after a letter or for a word break
// -----------------------------------------------------------------------------
module morse_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic [7:0] i_char,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_led,
    output logic       o_busy,
    output logic       o_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_N = PTR_W + 1;
    localparam int GAP_W = $clog2(WORD_GAP);

    localparam logic [PTR_N-1:0] DEPTH_CNT     = PTR_N'(FIFO_DEPTH);
    localparam logic [PTR_N-1:0] PTR_ONE       = PTR_N'(1);
    localparam logic [GAP_W-1:0] GAP_ONE       = GAP_W'(1);
    localparam logic [GAP_W-1:0] WORD_RELOAD   = GAP_W'(WORD_GAP - 1);
    localparam logic [GAP_W-1:0] LETTER_RELOAD = GAP_W'(LETTER_GAP - 1);
    // A space following a completed letter gap only needs the remainder of
    // the word gap, since LETTER_GAP off units have already been emitted.
    localparam logic [GAP_W-1:0] SPACE_RELOAD  = GAP_W'(WORD_GAP - LETTER_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYMBOL = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Morse ROM: returns {pattern[19:0] left-justified, length[4:0]}.
    // The table holds the dot/dash code compactly (symbol count plus one bit
    // per symbol, 1 = dash, written in reading order) and the loop expands it
    // into the unit pattern: dot = 1, dash = 111, one 0 between symbols.
    // -------------------------------------------------------------------------
    function automatic logic [24:0] morse_rom(input logic [7:0] c);
        logic [2:0]  n_sym;
        logic [4:0]  code;
        logic [19:0] pat;
        logic [4:0]  len;
        n_sym = 3'd0;
        code  = 5'd0;
        pat   = '0;
        len   = '0;
        case (c)
            8'h41: {n_sym, code} = {3'd2, 5'b00001};   // A .-
            8'h42: {n_sym, code} = {3'd4, 5'b01000};   // B -...
            8'h43: {n_sym, code} = {3'd4, 5'b01010};   // C -.-.
            8'h44: {n_sym, code} = {3'd3, 5'b00100};   // D -..
            8'h45: {n_sym, code} = {3'd1, 5'b00000};   // E .
            8'h46: {n_sym, code} = {3'd4, 5'b00010};   // F ..-.
            8'h47: {n_sym, code} = {3'd3, 5'b00110};   // G --.
            8'h48: {n_sym, code} = {3'd4, 5'b00000};   // H ....
            8'h49: {n_sym, code} = {3'd2, 5'b00000};   // I ..
            8'h4A: {n_sym, code} = {3'd4, 5'b00111};   // J .---
            8'h4B: {n_sym, code} = {3'd3, 5'b00101};   // K -.-
            8'h4C: {n_sym, code} = {3'd4, 5'b00100};   // L .-..
            8'h4D: {n_sym, code} = {3'd2, 5'b00011};   // M --
            8'h4E: {n_sym, code} = {3'd2, 5'b00010};   // N -.
            8'h4F: {n_sym, code} = {3'd3, 5'b00111};   // O ---
            8'h50: {n_sym, code} = {3'd4, 5'b00110};   // P .--.
            8'h51: {n_sym, code} = {3'd4, 5'b01101};   // Q --.-
            8'h52: {n_sym, code} = {3'd3, 5'b00010};   // R .-.
            8'h53: {n_sym, code} = {3'd3, 5'b00000};   // S ...
            8'h54: {n_sym, code} = {3'd1, 5'b00001};   // T -
            8'h55: {n_sym, code} = {3'd3, 5'b00001};   // U ..-
            8'h56: {n_sym, code} = {3'd4, 5'b00001};   // V ...-
            8'h57: {n_sym, code} = {3'd3, 5'b00011};   // W .--
            8'h58: {n_sym, code} = {3'd4, 5'b01001};   // X -..-
            8'h59: {n_sym, code} = {3'd4, 5'b01011};   // Y -.--
            8'h5A: {n_sym, code} = {3'd4, 5'b01100};   // Z --..
            8'h30: {n_sym, code} = {3'd5, 5'b11111};   // 0 -----
            8'h31: {n_sym, code} = {3'd5, 5'b01111};   // 1 .----
            8'h32: {n_sym, code} = {3'd5, 5'b00111};   // 2 ..---
            8'h33: {n_sym, code} = {3'd5, 5'b00011};   // 3 ...--
            8'h34: {n_sym, code} = {3'd5, 5'b00001};   // 4 ....-
            8'h35: {n_sym, code} = {3'd5, 5'b00000};   // 5 .....
            8'h36: {n_sym, code} = {3'd5, 5'b10000};   // 6 -....
            8'h37: {n_sym, code} = {3'd5, 5'b11000};   // 7 --...
            8'h38: {n_sym, code} = {3'd5, 5'b11100};   // 8 ---..
            8'h39: {n_sym, code} = {3'd5, 5'b11110};   // 9 ----.
            default: {n_sym, code} = {3'd0, 5'b00000};
        endcase
        // Left-justify so that symbol i always sits at code[4-i].
        code = code << (3'd5 - n_sym);
        for (int i = 0; i < 5; i++) begin
            if (i < int'(n_sym)) begin
                if (i != 0) begin
                    len = len + 5'd1;
                end
                if (code[4-i]) begin
                    pat[5'd19 - len] = 1'b1;
                    pat[5'd18 - len] = 1'b1;
                    pat[5'd17 - len] = 1'b1;
                    len              = len + 5'd3;
                end else begin
                    pat[5'd19 - len] = 1'b1;
                    len              = len + 5'd1;
                end
            end
        end
        return {pat, len};
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic             led_q,     led_d;
    logic             err_q,     err_d;
    logic [19:0]      shreg_q,   shreg_d;
    logic [4:0]       bit_rem_q, bit_rem_d;
    logic [GAP_W-1:0] gap_rem_q, gap_rem_d;
    logic [PTR_N-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_N-1:0] rd_ptr_q,  rd_ptr_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [7:0]       fifo_mem_d [FIFO_DEPTH];

    // -------------------------------------------------------------------------
    // Input side: fold case, classify, handshake
    // -------------------------------------------------------------------------
    logic [7:0]       char_up;
    logic             char_ok;
    logic [PTR_N-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             push;
    logic             pop;

    assign char_up = (i_char >= 8'h61 && i_char <= 8'h7A) ? (i_char - 8'h20) : i_char;
    assign char_ok = (char_up >= 8'h41 && char_up <= 8'h5A) ||
                     (char_up >= 8'h30 && char_up <= 8'h39) ||
                     (char_up == 8'h20);

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    // Readiness comes only from registered state, so a same-cycle pop never
    // opens a slot for a push.
    assign accept = i_valid && !fifo_full;
    assign push   = accept && char_ok;
    assign err_d  = accept && !char_ok;

    // -------------------------------------------------------------------------
    // FIFO head decode
    // -------------------------------------------------------------------------
    logic [7:0]  head_char;
    logic        head_space;
    logic [24:0] rom_entry;
    logic [19:0] rom_pattern;
    logic [4:0]  rom_len;

    assign head_char               = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_space              = (head_char == 8'h20);
    assign rom_entry               = morse_rom(head_char);
    assign {rom_pattern, rom_len}  = rom_entry;

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = char_up;
            wr_ptr_d                        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer next state
    // -------------------------------------------------------------------------
    logic start_letter;

    always_comb begin
        state_d      = state_q;
        led_d        = led_q;
        shreg_d      = shreg_q;
        bit_rem_d    = bit_rem_q;
        gap_rem_d    = gap_rem_q;
        pop          = 1'b0;
        start_letter = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_tick && !fifo_empty) begin
                    if (head_space) begin
                        pop       = 1'b1;
                        led_d     = 1'b0;
                        gap_rem_d = WORD_RELOAD;
                        state_d   = ST_GAP;
                    end else begin
                        start_letter = 1'b1;
                    end
                end
            end
            ST_SYMBOL: begin
                if (i_tick) begin
                    if (bit_rem_q != 5'd0) begin
                        led_d     = shreg_q[19];
                        shreg_d   = shreg_q << 1;
                        bit_rem_d = bit_rem_q - 5'd1;
                    end else begin
                        led_d     = 1'b0;
                        gap_rem_d = LETTER_RELOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (i_tick) begin
                    if (gap_rem_q != '0) begin
                        gap_rem_d = gap_rem_q - GAP_ONE;
                    end else if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else if (head_space) begin
                        pop       = 1'b1;
                        gap_rem_d = SPACE_RELOAD;
                    end else begin
                        start_letter = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
            end
        endcase

        // First unit goes straight to the LED; the shift register keeps the rest.
        if (start_letter) begin
            pop       = 1'b1;
            led_d     = rom_pattern[19];
            shreg_d   = rom_pattern << 1;
            bit_rem_d = rom_len - 5'd1;
            state_d   = ST_SYMBOL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            led_q      <= 1'b0;
            err_q      <= 1'b0;
            shreg_q    <= '0;
            bit_rem_q  <= '0;
            gap_rem_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            err_q      <= err_d;
            shreg_q    <= shreg_d;
            bit_rem_q  <= bit_rem_d;
            gap_rem_q  <= gap_rem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign o_ready = !fifo_full;
    assign o_led   = led_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_morse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_morse_sequencer
//
// Drives characters and unit ticks into morse_sequencer and compares every
// output on every cycle against a unit-level reference model: each character
// taken from the model FIFO is expanded into a queue of on/off units (letter
// pattern plus letter gap, or a word-gap run for a space), and each tick plays
// one unit. Directed scenarios also compare captured unit strings to literals.
// -----------------------------------------------------------------------------
module tb_morse_sequencer;

    localparam int DEPTH = 4;
    localparam int LGAP  = 3;
    localparam int WGAP  = 7;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_tick;
    logic [7:0] i_char;
    logic       i_valid;
    logic       o_ready;
    logic       o_led;
    logic       o_busy;
    logic       o_err;

    morse_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .LETTER_GAP (LGAP),
        .WORD_GAP   (WGAP)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tick  (i_tick),
        .i_char  (i_char),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_led   (o_led),
        .o_busy  (o_busy),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int    n_checks = 0;
    int    n_errs   = 0;
    int    tick_mode = 0;      // 0 none, >0 period in cycles, <0 random
    int    tick_ctr  = 0;
    bit    tick_req  = 1'b0;   // one-shot extra tick
    string cap = "";           // LED value seen after each tick

    logic [7:0] m_fifo[$];
    bit         m_units[$];
    bit         m_led;
    bit         m_active;
    bit         m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= "a" && c <= "z") ? (c - 8'd32) : c;
    endfunction

    function automatic string morse_of(input logic [7:0] c);
        case (fold(c))
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: return "";
        endcase
    endfunction

    function automatic bit is_supported(input logic [7:0] c);
        return (c == " ") || (morse_of(c).len() != 0);
    endfunction

    function automatic logic [63:0] bits_of(input string s);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < s.len(); i++) v = {v[62:0], (s[i] == "1")};
        return v;
    endfunction

    function automatic int ones(input string s);
        int n;
        n = 0;
        for (int i = 0; i < s.len(); i++) if (s[i] == "1") n++;
        return n;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_units.delete();
        m_led    = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs sampled at it.
    task automatic model_step();
        logic [7:0] c;
        bit         acc;
        string      m;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        acc = i_valid && (m_fifo.size() < DEPTH);
        if (i_tick) begin
            if (m_units.size() == 0 && m_fifo.size() != 0) begin
                c = m_fifo.pop_front();
                if (c == " ") begin
                    repeat (m_active ? (WGAP - LGAP) : WGAP) m_units.push_back(1'b0);
                end else begin
                    m = morse_of(c);
                    for (int i = 0; i < m.len(); i++) begin
                        if (i != 0) m_units.push_back(1'b0);
                        if (m[i] == "-") repeat (3) m_units.push_back(1'b1);
                        else m_units.push_back(1'b1);
                    end
                    repeat (LGAP) m_units.push_back(1'b0);
                end
                m_active = 1'b1;
            end
            if (m_units.size() != 0) m_led = m_units.pop_front();
            else m_active = 1'b0;
        end
        m_err = acc && !is_supported(i_char);
        if (acc && is_supported(i_char)) m_fifo.push_back(fold(i_char));
    endtask

    // Starts and ends on a falling edge; inputs other than i_tick are set by the caller.
    task automatic cycle();
        bit t;
        if (tick_mode > 0) begin
            t        = (tick_ctr == 0);
            tick_ctr = (tick_ctr + 1) % tick_mode;
        end else if (tick_mode < 0) begin
            t = ($urandom_range(0, 3) == 0);
        end else begin
            t = 1'b0;
        end
        t        = t | tick_req;
        tick_req = 1'b0;
        i_tick   = t;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk("led",   o_led,   m_led);
        chk("ready", o_ready, m_fifo.size() < DEPTH);
        chk("busy",  o_busy,  m_active || (m_fifo.size() != 0));
        chk("err",   o_err,   m_err);
        if (t) begin
            if (o_led) cap = {cap, "1"};
            else       cap = {cap, "0"};
        end
        i_tick = 1'b0;
    endtask

    task automatic push(input logic [7:0] c);
        int k;
        k       = 0;
        i_valid = 1'b1;
        i_char  = c;
        while (!o_ready && k < 300) begin
            cycle();
            k++;
        end
        chk("push_ready", o_ready, 1'b1);
        cycle();
        i_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (o_busy && k < budget) begin
            cycle();
            k++;
        end
        chk("idle_timeout", o_busy, 1'b0);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_tick  = 1'b0;
        i_valid = 1'b0;
        i_char  = 8'h00;
        model_reset();
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_char();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: return 8'(8'h41 + $urandom_range(0, 25));
            3, 4:    return 8'(8'h61 + $urandom_range(0, 25));
            5, 6:    return 8'(8'h30 + $urandom_range(0, 9));
            7:       return 8'h20;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b1;
        i_tick  = 1'b0;
        i_valid = 1'b0;
        i_char  = 8'h00;
        @(negedge i_clk);
        do_reset();
        @(negedge i_clk);
        chk("rst_led",   o_led,   1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy",  o_busy,  1'b0);
        chk("rst_err",   o_err,   1'b0);

        // E then T, one tick every 10 cycles
        tick_mode = 0;
        push("E");
        push("T");
        tick_mode = 10; tick_ctr = 1; cap = "";
        wait_idle(400);
        chk("et_units", bits_of(cap), bits_of("10001110000"));

        // lowercase s, space, lowercase o
        tick_mode = 0;
        push("s");
        push(" ");
        push("o");
        tick_mode = 4; tick_ctr = 1; cap = "";
        wait_idle(600);
        chk("s_sp_o_units", bits_of(cap), bits_of("101010000000111011101110000"));

        // unsupported character
        tick_mode = 0;
        push("#");
        chk("err_pulse", o_err,  1'b1);
        chk("err_busy",  o_busy, 1'b0);
        cycle();
        chk("err_clear", o_err,  1'b0);
        chk("err_led",   o_led,  1'b0);

        // push and tick on the same edge must not start the character
        i_valid = 1'b1; i_char = "T"; tick_req = 1'b1;
        cycle();
        i_valid = 1'b0;
        chk("same_edge_led",  o_led,  1'b0);
        chk("same_edge_busy", o_busy, 1'b1);
        tick_req = 1'b1;
        cycle();
        chk("next_tick_led", o_led, 1'b1);
        tick_mode = 1; tick_ctr = 0;
        wait_idle(200);

        // fill the FIFO with ticks held off
        tick_mode = 0;
        push("A"); push("B"); push("C"); push("D");
        chk("full_ready", o_ready, 1'b0);
        i_valid = 1'b1; i_char = "E";
        repeat (3) cycle();
        chk("held_ready", o_ready, 1'b0);
        tick_req = 1'b1;
        cycle();
        chk("pop_ready", o_ready, 1'b1);
        cycle();
        i_valid = 1'b0;
        chk("refill_ready", o_ready, 1'b0);
        tick_mode = 1; tick_ctr = 0;
        wait_idle(2000);

        // reset in the middle of digit 0, A queued behind it
        tick_mode = 0;
        push("0");
        push("A");
        tick_mode = 2; tick_ctr = 1; cap = "";
        begin
            int k;
            k = 0;
            while (cap.len() < 9 && k < 200) begin
                cycle();
                k++;
            end
        end
        chk("mid_units", bits_of(cap), bits_of("111011101"));
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_led",   o_led,   1'b0);
        chk("mid_rst_ready", o_ready, 1'b1);
        chk("mid_rst_busy",  o_busy,  1'b0);
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick_mode = 1; tick_ctr = 0; cap = "";
        repeat (40) cycle();
        chk("a_dropped", ones(cap), 0);

        // two spaces then E from idle
        tick_mode = 0;
        push(" ");
        push(" ");
        push("E");
        tick_mode = 3; tick_ctr = 1; cap = "";
        wait_idle(300);
        chk("sp_sp_e_units", bits_of(cap), bits_of("0000000000010000"));

        // randomized traffic against the model
        tick_mode = -1;
        repeat (3000) begin
            i_valid = ($urandom_range(0, 2) == 0);
            i_char  = rand_char();
            cycle();
        end
        i_valid = 1'b0;
        wait_idle(5000);

        // randomized traffic with back-to-back ticks
        tick_mode = 1; tick_ctr = 0;
        repeat (1000) begin
            i_valid = ($urandom_range(0, 1) == 0);
            i_char  = rand_char();
            cycle();
        end
        i_valid = 1'b0;
        wait_idle(2000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
